// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arbiter_pkg
//   Shared definitions for the packet-granular AXI4-Stream round-robin
//   arbiter: default stream widths, the arbiter FSM state type and the
//   position of the optional source tag inside tuser.
// ---------------------------------------------------------------------------
package axis_pkt_rr_arbiter_pkg;

  localparam int DEF_AXIS_DATA_WIDTH  = 512;
  localparam int DEF_AXIS_TUSER_WIDTH = 256;

  // Source tag occupies the top byte of tuser: [TUSER_WIDTH-1 -: SRC_TAG_W].
  localparam int SRC_TAG_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

endpackage : axis_pkt_rr_arbiter_pkg

// File: rtl/axis_pkt_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arbiter_rr_pick
//   Combinational round-robin priority encoder. Scans the request vector
//   starting one position after last_grant, wrapping modulo NUM_IN, and
//   returns the first requester found.
//
// Ports
//   req        in  NUM_IN        request vector (one bit per input)
//   last_grant in  $clog2(NUM_IN) input served most recently
//   grant      out $clog2(NUM_IN) selected input (last_grant when no request)
//   any_req    out 1             at least one request bit is set
// ---------------------------------------------------------------------------
module axis_pkt_rr_arbiter_rr_pick #(
  parameter  int NUM_IN = 4,
  localparam int IDXW   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDXW-1:0]   last_grant,
  output logic [IDXW-1:0]   grant,
  output logic              any_req
);

  logic [IDXW-1:0] cand;

  // NOTE: every variable written in always_comb gets a default on entry so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant   = last_grant;
    any_req = |req;
    cand    = '0;
    // Walk the rotation from farthest to nearest; the nearest requester is
    // written last and therefore wins.
    for (int off = NUM_IN; off >= 1; off--) begin
      cand = IDXW'((int'(last_grant) + off) % NUM_IN);
      if (req[cand]) grant = cand;
    end
  end

endmodule : axis_pkt_rr_arbiter_rr_pick

// File: rtl/axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arbiter
//   Merges NUM_IN AXI4-Stream ingress streams onto one egress stream. One
//   input is granted per packet; the grant is held until that packet's tlast
//   beat is accepted downstream, and tready is returned only to the granted
//   input. A one-cycle IDLE arbitration bubble separates packets. Per-input
//   packet counters (wrapping) expose traffic share.
//
// Ports
//   axis_aclk      in   clock for all logic
//   axis_reset     in   synchronous, active-high reset
//   s_axis_tdata   in   NUM_IN*AXIS_DATA_WIDTH, input i at slice i
//   s_axis_tkeep   in   NUM_IN*AXIS_DATA_WIDTH/8
//   s_axis_tuser   in   NUM_IN*AXIS_TUSER_WIDTH
//   s_axis_tvalid  in   NUM_IN
//   s_axis_tready  out  NUM_IN, only the granted bit can be high
//   s_axis_tlast   in   NUM_IN
//   m_axis_t*      out  merged stream (all zero outside PASS)
//   m_axis_tready  in   downstream ready
//   grant_idx      out  currently / most recently granted input
//   busy           out  high while a packet is being passed
//   pkt_cnt        out  NUM_IN*CNT_WIDTH, packets forwarded per input
//
// Build option
//   ARB_SRC_TAG_EN : when defined, the top byte of m_axis_tuser carries the
//                    zero-extended grant_idx during PASS.
// ---------------------------------------------------------------------------
module axis_pkt_rr_arbiter
  import axis_pkt_rr_arbiter_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = DEF_AXIS_DATA_WIDTH,
  parameter int AXIS_TUSER_WIDTH = DEF_AXIS_TUSER_WIDTH,
  parameter int NUM_IN           = 4,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                                  axis_aclk,
  input  logic                                  axis_reset,
  input  logic [NUM_IN*AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_IN*AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [NUM_IN*AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [NUM_IN-1:0]                     s_axis_tvalid,
  output logic [NUM_IN-1:0]                     s_axis_tready,
  input  logic [NUM_IN-1:0]                     s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [$clog2(NUM_IN)-1:0]             grant_idx,
  output logic                                  busy,
  output logic [NUM_IN*CNT_WIDTH-1:0]           pkt_cnt
);

  localparam int IDXW  = $clog2(NUM_IN);
  localparam int KEEPW = AXIS_DATA_WIDTH / 8;

  arb_state_t      state;
  logic [IDXW-1:0] last_grant;
  logic [IDXW-1:0] pick_idx;
  logic            any_req;
  logic            pkt_done;

  axis_pkt_rr_arbiter_rr_pick #(
    .NUM_IN (NUM_IN)
  ) u_rr_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .grant      (pick_idx),
    .any_req    (any_req)
  );

  // Egress mux driven from the registered grant: no added beat latency.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == PASS) begin
      m_axis_tdata  = s_axis_tdata[grant_idx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[grant_idx*KEEPW +: KEEPW];
      m_axis_tuser  = s_axis_tuser[grant_idx*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
      m_axis_tvalid = s_axis_tvalid[grant_idx];
      m_axis_tlast  = s_axis_tlast[grant_idx];
      s_axis_tready[grant_idx] = m_axis_tready;
`ifdef ARB_SRC_TAG_EN
      m_axis_tuser[AXIS_TUSER_WIDTH-1 -: SRC_TAG_W] = SRC_TAG_W'(grant_idx);
`endif
    end
  end

  assign pkt_done = (state == PASS) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      // Starting at NUM_IN-1 makes input 0 the first candidate after reset.
      grant_idx  <= IDXW'(NUM_IN - 1);
      last_grant <= IDXW'(NUM_IN - 1);
      pkt_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            state     <= PASS;
          end
        end
        PASS: begin
          // Grant is held through tvalid gaps; only the tlast handshake
          // releases it.
          if (pkt_done) begin
            pkt_cnt[grant_idx*CNT_WIDTH +: CNT_WIDTH] <=
              pkt_cnt[grant_idx*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
            last_grant <= grant_idx;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : axis_pkt_rr_arbiter

// File: tb/tb_axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_rr_arbiter
//   Directed bench for axis_pkt_rr_arbiter with 4 inputs, 32-bit data,
//   16-bit tuser and 4-bit packet counters. Every source beat carries
//   tdata = {input, packet number, beat number} so egress order is directly
//   readable against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_axis_pkt_rr_arbiter;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 16;
  localparam int CW = 4;

  logic              axis_aclk = 1'b0;
  logic              axis_reset;
  logic [NI*DW-1:0]  s_axis_tdata;
  logic [NI*KW-1:0]  s_axis_tkeep;
  logic [NI*UW-1:0]  s_axis_tuser;
  logic [NI-1:0]     s_axis_tvalid;
  logic [NI-1:0]     s_axis_tready;
  logic [NI-1:0]     s_axis_tlast;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [1:0]        grant_idx;
  logic              busy;
  logic [NI*CW-1:0]  pkt_cnt;

  axis_pkt_rr_arbiter #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_TUSER_WIDTH(UW),
    .NUM_IN          (NI),
    .CNT_WIDTH       (CW)
  ) dut (
    .axis_aclk    (axis_aclk),
    .axis_reset   (axis_reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 axis_aclk = ~axis_aclk;

  int checks = 0;
  int errors = 0;

  // Source state per input.
  int plen[NI];
  int beat_no[NI];
  int pkt_no[NI];
  int pkts_left[NI];
  bit hold[NI];
  bit user_ones;
  logic [NI-1:0] fire;

  // Egress log.
  logic [DW-1:0] out_data_q[$];
  logic          out_last_q[$];
  logic [UW-1:0] out_user_q[$];

  task automatic drive_sources();
    for (int i = 0; i < NI; i++) begin
      s_axis_tvalid[i]         = (pkts_left[i] > 0) && !hold[i];
      s_axis_tlast[i]          = (beat_no[i] == plen[i] - 1);
      s_axis_tdata[i*DW +: DW] = {8'(i), 8'(pkt_no[i]), 16'(beat_no[i])};
      s_axis_tkeep[i*KW +: KW] = 4'(beat_no[i] + i + 1);
      s_axis_tuser[i*UW +: UW] = user_ones ? 16'hFFFF : {8'(8'hA0 + i), 8'(beat_no[i])};
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NI; i++) begin
      plen[i] = 0; beat_no[i] = 0; pkt_no[i] = 0; pkts_left[i] = 0; hold[i] = 1'b0;
    end
    user_ones = 1'b0;
    fire = '0;
    drive_sources();
  endtask

  // Observe at the falling edge: log accepted egress beats and ingress handshakes.
  task automatic sample();
    @(negedge axis_aclk);
    if (m_axis_tvalid && m_axis_tready) begin
      out_data_q.push_back(m_axis_tdata);
      out_last_q.push_back(m_axis_tlast);
      out_user_q.push_back(m_axis_tuser);
    end
    fire = s_axis_tvalid & s_axis_tready;
  endtask

  // Cross the rising edge and move each source past any beat it handed over.
  task automatic advance();
    @(posedge axis_aclk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (fire[i]) begin
        if (beat_no[i] == plen[i] - 1) begin
          beat_no[i] = 0; pkt_no[i]++; pkts_left[i]--;
        end else begin
          beat_no[i]++;
        end
      end
    end
    drive_sources();
  endtask

  task automatic run_beats(input int n, input int budget, output int used);
    used = 0;
    while (out_data_q.size() < n && used < budget) begin
      sample();
      advance();
      used++;
    end
    checks++;
    if (out_data_q.size() < n) begin
      errors++;
      $display("FAIL run_beats timeout: got %0d beats, required %0d", out_data_q.size(), n);
    end
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    clear_sources();
    repeat (2) begin @(posedge axis_aclk); #1; end
    axis_reset = 1'b0;
    out_data_q.delete(); out_last_q.delete(); out_user_q.delete();
  endtask

  // Reset state while a source is already presenting a packet.
  task automatic test_reset();
    axis_reset = 1'b1;
    clear_sources();
    pkts_left[0] = 1; plen[0] = 2;
    drive_sources();
    repeat (3) begin @(posedge axis_aclk); #1; end
    sample();
    checks += 8;
    if (busy !== 1'b0)          begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    if (grant_idx !== 2'd3)     begin errors++; $display("FAIL reset grant_idx: got %0d required 3", grant_idx); end
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset m_tvalid: got %b required 0", m_axis_tvalid); end
    if (m_axis_tlast !== 1'b0)  begin errors++; $display("FAIL reset m_tlast: got %b required 0", m_axis_tlast); end
    if (m_axis_tdata !== '0)    begin errors++; $display("FAIL reset m_tdata: got %h required 0", m_axis_tdata); end
    if (m_axis_tuser !== '0)    begin errors++; $display("FAIL reset m_tuser: got %h required 0", m_axis_tuser); end
    if (s_axis_tready !== '0)   begin errors++; $display("FAIL reset s_tready: got %b required 0000", s_axis_tready); end
    if (pkt_cnt !== '0)         begin errors++; $display("FAIL reset pkt_cnt: got %h required 0", pkt_cnt); end
    do_reset();
  endtask

  // One 3-beat packet on input 0 with downstream always ready.
  task automatic test_single();
    logic [UW-1:0] exp_user;
    do_reset();
    pkts_left[0] = 1; plen[0] = 3;
    drive_sources();
    sample();
    checks += 3;
    if (busy !== 1'b0)          begin errors++; $display("FAIL single idle busy: got %b required 0", busy); end
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single idle m_tvalid: got %b required 0", m_axis_tvalid); end
    if (s_axis_tready !== '0)   begin errors++; $display("FAIL single idle s_tready: got %b required 0000", s_axis_tready); end
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
`ifdef ARB_SRC_TAG_EN
      exp_user = {8'h00, 8'(k)};
`else
      exp_user = {8'hA0, 8'(k)};
`endif
      checks += 7;
      if (busy !== 1'b1)                  begin errors++; $display("FAIL single busy beat%0d: got %b required 1", k, busy); end
      if (grant_idx !== 2'd0)             begin errors++; $display("FAIL single grant beat%0d: got %0d required 0", k, grant_idx); end
      if (m_axis_tdata !== 32'(k))        begin errors++; $display("FAIL single tdata beat%0d: got %h required %h", k, m_axis_tdata, 32'(k)); end
      if (m_axis_tkeep !== 4'(k + 1))     begin errors++; $display("FAIL single tkeep beat%0d: got %h required %h", k, m_axis_tkeep, 4'(k + 1)); end
      if (m_axis_tuser !== exp_user)      begin errors++; $display("FAIL single tuser beat%0d: got %h required %h", k, m_axis_tuser, exp_user); end
      if (m_axis_tlast !== (k == 2))      begin errors++; $display("FAIL single tlast beat%0d: got %b required %b", k, m_axis_tlast, (k == 2)); end
      if (s_axis_tready !== 4'b0001)      begin errors++; $display("FAIL single s_tready beat%0d: got %b required 0001", k, s_axis_tready); end
      advance();
    end
    sample();
    checks += 3;
    if (busy !== 1'b0)          begin errors++; $display("FAIL single done busy: got %b required 0", busy); end
    if (grant_idx !== 2'd0)     begin errors++; $display("FAIL single done grant: got %0d required 0", grant_idx); end
    if (pkt_cnt !== 16'h0001)   begin errors++; $display("FAIL single pkt_cnt: got %h required 0001", pkt_cnt); end
    advance();
  endtask

  // All inputs with two 2-beat packets each: strict rotation 0,1,2,3,0,1,2,3.
  task automatic test_rotation();
    int used;
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 0; i < NI; i++) begin pkts_left[i] = 2; plen[i] = 2; end
    drive_sources();
    run_beats(16, 60, used);
    checks++;
    if (used !== 24) begin errors++; $display("FAIL rotation cycles: got %0d required 24", used); end
    for (int k = 0; k < 8 && out_data_q.size() >= 16; k++) begin
      for (int b = 0; b < 2; b++) begin
        exp = {8'(k % 4), 8'(k / 4), 16'(b)};
        checks += 2;
        if (out_data_q[2*k+b] !== exp)        begin errors++; $display("FAIL rotation data pkt%0d beat%0d: got %h required %h", k, b, out_data_q[2*k+b], exp); end
        if (out_last_q[2*k+b] !== (b == 1))   begin errors++; $display("FAIL rotation last pkt%0d beat%0d: got %b required %b", k, b, out_last_q[2*k+b], (b == 1)); end
      end
    end
    sample();
    checks++;
    if (pkt_cnt !== 16'h2222) begin errors++; $display("FAIL rotation pkt_cnt: got %h required 2222", pkt_cnt); end
    advance();
  endtask

  // Single-beat packet on input 1, then inputs 1 and 3 compete: 3 wins, then 1.
  task automatic test_pair();
    int used;
    do_reset();
    pkts_left[1] = 1; plen[1] = 1;
    drive_sources();
    run_beats(1, 10, used);
    checks++;
    if (used !== 2) begin errors++; $display("FAIL pair single-beat cycles: got %0d required 2", used); end
    sample();
    checks += 3;
    if (busy !== 1'b0)        begin errors++; $display("FAIL pair single-beat busy: got %b required 0", busy); end
    if (grant_idx !== 2'd1)   begin errors++; $display("FAIL pair grant: got %0d required 1", grant_idx); end
    if (pkt_cnt !== 16'h0010) begin errors++; $display("FAIL pair pkt_cnt first: got %h required 0010", pkt_cnt); end
    pkts_left[1] = 1; plen[1] = 2;
    pkts_left[3] = 1; plen[3] = 2;
    drive_sources();
    advance();
    run_beats(5, 20, used);
    if (out_data_q.size() >= 5) begin
      checks += 5;
      if (out_data_q[1] !== 32'h0300_0000) begin errors++; $display("FAIL pair order b1: got %h required 03000000", out_data_q[1]); end
      if (out_data_q[2] !== 32'h0300_0001) begin errors++; $display("FAIL pair order b2: got %h required 03000001", out_data_q[2]); end
      if (out_data_q[3] !== 32'h0101_0000) begin errors++; $display("FAIL pair order b3: got %h required 01010000", out_data_q[3]); end
      if (out_data_q[4] !== 32'h0101_0001) begin errors++; $display("FAIL pair order b4: got %h required 01010001", out_data_q[4]); end
      if (out_last_q[2] !== 1'b1)          begin errors++; $display("FAIL pair last b2: got %b required 1", out_last_q[2]); end
    end
    sample();
    checks++;
    if (pkt_cnt !== 16'h1020) begin errors++; $display("FAIL pair pkt_cnt: got %h required 1020", pkt_cnt); end
    advance();
  endtask

  // Downstream ready toggling during a 4-beat packet from input 0 while input 2 waits.
  task automatic test_backpressure();
    do_reset();
    pkts_left[0] = 1; plen[0] = 4;
    pkts_left[2] = 1; plen[2] = 1;
    drive_sources();
    m_axis_tready = 1'b1;
    for (int cyc = 0; cyc < 40 && out_data_q.size() < 5; cyc++) begin
      sample();
      if (busy && grant_idx == 2'd0) begin
        checks += 3;
        if (s_axis_tready !== {3'b000, m_axis_tready}) begin errors++; $display("FAIL bp s_tready cyc%0d: got %b required %b", cyc, s_axis_tready, {3'b000, m_axis_tready}); end
        if (m_axis_tvalid !== 1'b1)                     begin errors++; $display("FAIL bp m_tvalid cyc%0d: got %b required 1", cyc, m_axis_tvalid); end
        if (m_axis_tdata !== s_axis_tdata[0 +: DW])     begin errors++; $display("FAIL bp hold data cyc%0d: got %h required %h", cyc, m_axis_tdata, s_axis_tdata[0 +: DW]); end
      end
      advance();
      m_axis_tready = ~m_axis_tready;
    end
    m_axis_tready = 1'b1;
    checks++;
    if (out_data_q.size() != 5) begin
      errors++; $display("FAIL bp beat count: got %0d required 5", out_data_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks += 2;
        if (out_data_q[k] !== 32'(k))      begin errors++; $display("FAIL bp data beat%0d: got %h required %h", k, out_data_q[k], 32'(k)); end
        if (out_last_q[k] !== (k == 3))    begin errors++; $display("FAIL bp last beat%0d: got %b required %b", k, out_last_q[k], (k == 3)); end
      end
      checks++;
      if (out_data_q[4] !== 32'h0200_0000) begin errors++; $display("FAIL bp next packet: got %h required 02000000", out_data_q[4]); end
    end
  endtask

  // Granted input drops tvalid mid-packet: grant held, no regrant to input 1.
  task automatic test_gap();
    int used;
    do_reset();
    pkts_left[0] = 1; plen[0] = 3;
    pkts_left[1] = 1; plen[1] = 1;
    drive_sources();
    run_beats(1, 10, used);
    hold[0] = 1'b1;
    drive_sources();
    for (int c = 0; c < 2; c++) begin
      sample();
      checks += 4;
      if (busy !== 1'b1)             begin errors++; $display("FAIL gap busy c%0d: got %b required 1", c, busy); end
      if (grant_idx !== 2'd0)        begin errors++; $display("FAIL gap grant c%0d: got %0d required 0", c, grant_idx); end
      if (m_axis_tvalid !== 1'b0)    begin errors++; $display("FAIL gap m_tvalid c%0d: got %b required 0", c, m_axis_tvalid); end
      if (s_axis_tready !== 4'b0001) begin errors++; $display("FAIL gap s_tready c%0d: got %b required 0001", c, s_axis_tready); end
      advance();
    end
    hold[0] = 1'b0;
    drive_sources();
    run_beats(4, 20, used);
    if (out_data_q.size() >= 4) begin
      checks += 4;
      if (out_data_q[1] !== 32'h0000_0001) begin errors++; $display("FAIL gap b1: got %h required 00000001", out_data_q[1]); end
      if (out_data_q[2] !== 32'h0000_0002) begin errors++; $display("FAIL gap b2: got %h required 00000002", out_data_q[2]); end
      if (out_last_q[2] !== 1'b1)          begin errors++; $display("FAIL gap last b2: got %b required 1", out_last_q[2]); end
      if (out_data_q[3] !== 32'h0100_0000) begin errors++; $display("FAIL gap next packet: got %h required 01000000", out_data_q[3]); end
    end
  endtask

  // Reset raised on beat 2 of a 5-beat packet from input 0.
  task automatic test_reset_mid();
    int used;
    pkts_left[0] = 1; plen[0] = 5;
    drive_sources();
    run_beats(out_data_q.size() + 2, 10, used);
    axis_reset = 1'b1;
    sample();
    checks += 2;
    if (busy !== 1'b1)        begin errors++; $display("FAIL rstmid pre busy: got %b required 1", busy); end
    if (pkt_cnt !== 16'h0011) begin errors++; $display("FAIL rstmid pre pkt_cnt: got %h required 0011", pkt_cnt); end
    advance();
    sample();
    checks += 5;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid m_tvalid: got %b required 0", m_axis_tvalid); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rstmid busy: got %b required 0", busy); end
    if (grant_idx !== 2'd3)     begin errors++; $display("FAIL rstmid grant: got %0d required 3", grant_idx); end
    if (pkt_cnt !== '0)         begin errors++; $display("FAIL rstmid pkt_cnt: got %h required 0", pkt_cnt); end
    if (s_axis_tready !== '0)   begin errors++; $display("FAIL rstmid s_tready: got %b required 0000", s_axis_tready); end
    do_reset();
  endtask

  // 16 single-beat packets on input 0: the 4-bit counter reaches 15 then wraps to 0.
  task automatic test_wrap();
    int used;
    do_reset();
    pkts_left[0] = 16; plen[0] = 1;
    drive_sources();
    run_beats(15, 60, used);
    sample();
    checks++;
    if (pkt_cnt !== 16'h000F) begin errors++; $display("FAIL wrap cnt15: got %h required 000f", pkt_cnt); end
    advance();
    run_beats(16, 10, used);
    sample();
    checks++;
    if (pkt_cnt !== 16'h0000) begin errors++; $display("FAIL wrap cnt16: got %h required 0000", pkt_cnt); end
    advance();
  endtask

  // Input 2 packet with all-ones tuser: tag in the top byte only when enabled.
  task automatic test_src_tag();
    int used;
    logic [UW-1:0] exp_user;
    do_reset();
    user_ones = 1'b1;
    pkts_left[2] = 1; plen[2] = 2;
    drive_sources();
    run_beats(2, 10, used);
`ifdef ARB_SRC_TAG_EN
    exp_user = 16'h02FF;
`else
    exp_user = 16'hFFFF;
`endif
    if (out_data_q.size() >= 2) begin
      checks += 3;
      if (out_data_q[0] !== 32'h0200_0000) begin errors++; $display("FAIL tag data: got %h required 02000000", out_data_q[0]); end
      if (out_user_q[0] !== exp_user)      begin errors++; $display("FAIL tag tuser b0: got %h required %h", out_user_q[0], exp_user); end
      if (out_user_q[1] !== exp_user)      begin errors++; $display("FAIL tag tuser b1: got %h required %h", out_user_q[1], exp_user); end
    end
  endtask

  initial begin
    axis_reset    = 1'b1;
    m_axis_tready = 1'b1;
    clear_sources();
    test_reset();
    test_single();
    test_rotation();
    test_pair();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_wrap();
    test_src_tag();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_axis_pkt_rr_arbiter
